// File: rtl/fc_fixed_pkg.sv
// -----------------------------------------------------------------------------
// fc_fixed_pkg
// Shared definitions for the FC fixed-point datapath.
//   FC_N / FC_FRAC    : Q-format width and fractional bit count (Q5.10)
//   FC_QMAX / FC_QMIN : saturation limits of the 16-bit Q format
//   div_state_t       : control states of the sequential divider
// -----------------------------------------------------------------------------
package fc_fixed_pkg;

   localparam int          FC_N    = 16;
   localparam int          FC_FRAC = 10;
   localparam logic [15:0] FC_QMAX = 16'h7FFF;
   localparam logic [15:0] FC_QMIN = 16'h8000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } div_state_t;

endpackage : fc_fixed_pkg

// File: rtl/fixed_point_divider_if.sv
// -----------------------------------------------------------------------------
// fixed_point_divider_if
// Start/finish handshake and operand/result bus of the fixed-point divider.
//   enable      : start request (master -> divider)
//   dividend    : signed Q-format numerator (master -> divider)
//   divisor     : signed Q-format denominator (master -> divider)
//   quotient    : signed Q-format result (divider -> master)
//   finish      : result valid (divider -> master)
//   busy        : division in progress (divider -> master)
//   div_by_zero : result came from a zero divisor (divider -> master)
// -----------------------------------------------------------------------------
interface fixed_point_divider_if #(
   parameter int N = 16
) ();

   logic         enable;
   logic [N-1:0] dividend;
   logic [N-1:0] divisor;
   logic [N-1:0] quotient;
   logic         finish;
   logic         busy;
   logic         div_by_zero;

   modport master (
      output enable, dividend, divisor,
      input  quotient, finish, busy, div_by_zero
   );

   modport slave (
      input  enable, dividend, divisor,
      output quotient, finish, busy, div_by_zero
   );

endinterface : fixed_point_divider_if

// File: rtl/fixed_div_finalize.sv
// -----------------------------------------------------------------------------
// fixed_div_finalize
// Combinational result stage: optional rounding, sign application and
// saturation of the unsigned quotient magnitude to the signed N-bit Q format.
// Build option: FIXED_DIV_ROUND_EN selects round-half-away-from-zero;
// otherwise the magnitude is truncated (toward zero).
//   mag_i      : unsigned quotient magnitude, N+FRAC bits
//   rem_i      : final partial remainder, N bits
//   den_i      : divisor magnitude, N bits
//   sign_i     : 1 when the result is negative
//   quotient_o : signed, saturated N-bit quotient
// -----------------------------------------------------------------------------
module fixed_div_finalize
   import fc_fixed_pkg::*;
#(
   parameter int N    = FC_N,
   parameter int FRAC = FC_FRAC
) (
   input  logic [N+FRAC-1:0] mag_i,
   input  logic [N-1:0]      rem_i,
   input  logic [N-1:0]      den_i,
   input  logic              sign_i,
   output logic [N-1:0]      quotient_o
);

   localparam int MW = N + FRAC;

   // Largest positive magnitude and largest negative magnitude, one bit wider
   // than the magnitude so a rounding carry is never lost.
   localparam logic [MW:0] POS_LIM_C = (MW+1)'((64'd1 << (N-1)) - 64'd1);
   localparam logic [MW:0] NEG_LIM_C = (MW+1)'(64'd1 << (N-1));
   localparam logic [N-1:0] QMAX_C   = {1'b0, {(N-1){1'b1}}};
   localparam logic [N-1:0] QMIN_C   = {1'b1, {(N-1){1'b0}}};

   logic [MW:0] mag_rnd_s;

`ifdef FIXED_DIV_ROUND_EN
   logic round_up_s;

   // Round half away from zero: bump the magnitude when the leftover is at
   // least half the divisor; the sign is applied afterwards.
   always_comb begin
      round_up_s = ({rem_i, 1'b0} >= {1'b0, den_i});
      mag_rnd_s  = {1'b0, mag_i} + {{MW{1'b0}}, round_up_s};
   end
`else
   logic unused_s;

   // Truncation: the remainder and divisor play no part in the result.
   always_comb begin
      unused_s  = ^{rem_i, den_i};
      mag_rnd_s = {1'b0, mag_i};
   end
`endif

   // Apply sign and clamp to the representable range.
   always_comb begin
      quotient_o = {N{1'b0}};
      if (sign_i) begin
         if (mag_rnd_s > NEG_LIM_C) begin
            quotient_o = QMIN_C;
         end else begin
            quotient_o = ~mag_rnd_s[N-1:0] + {{(N-1){1'b0}}, 1'b1};
         end
      end else begin
         if (mag_rnd_s > POS_LIM_C) begin
            quotient_o = QMAX_C;
         end else begin
            quotient_o = mag_rnd_s[N-1:0];
         end
      end
   end

endmodule : fixed_div_finalize

// File: rtl/fixed_point_divider.sv
// -----------------------------------------------------------------------------
// fixed_point_divider
// Sequential signed Q-format divider: restoring division on magnitudes, one
// quotient bit per clock, N+FRAC iterations, then one finalize cycle.
// Build option: FIXED_DIV_ROUND_EN enables round-half-away-from-zero in the
// finalize stage (latency unchanged).
//   clk    : rising-edge clock
//   reset  : asynchronous active-low reset
//   div_if : slave side of the divider bus (enable/dividend/divisor in,
//            quotient/finish/busy/div_by_zero out, all outputs registered)
// -----------------------------------------------------------------------------
module fixed_point_divider
   import fc_fixed_pkg::*;
#(
   parameter int N    = FC_N,
   parameter int FRAC = FC_FRAC
) (
   input  logic                  clk,
   input  logic                  reset,
   fixed_point_divider_if.slave  div_if
);

   localparam int MW = N + FRAC;
   localparam int CW = $clog2(MW);
   localparam logic [CW-1:0] LAST_C = CW'(MW - 1);
   localparam logic [N-1:0]  QMAX_C = {1'b0, {(N-1){1'b1}}};
   localparam logic [N-1:0]  QMIN_C = {1'b1, {(N-1){1'b0}}};

   // Two's-complement magnitude; the most negative value maps to 2^(N-1),
   // which still fits as an unsigned N-bit number.
   function automatic logic [N-1:0] mag_of(input logic [N-1:0] v);
      if (v[N-1]) begin
         mag_of = ~v + {{(N-1){1'b0}}, 1'b1};
      end else begin
         mag_of = v;
      end
   endfunction

   div_state_t    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [MW-1:0] num_q, num_d;     // numerator bits shift out, quotient bits shift in
   logic [N-1:0]  rem_q, rem_d;
   logic [N-1:0]  den_q, den_d;
   logic          sign_q, sign_d;
   logic          dz_pend_q, dz_pend_d;
   logic [N-1:0]  quot_q, quot_d;
   logic          fin_q, fin_d;
   logic          busy_q, busy_d;
   logic          dbz_q, dbz_d;

   logic [N:0]    shift_s;
   logic [N:0]    diff_s;
   logic          qbit_s;
   logic [N-1:0]  final_s;

   fixed_div_finalize #(
      .N    (N),
      .FRAC (FRAC)
   ) u_finalize (
      .mag_i      (num_q),
      .rem_i      (rem_q),
      .den_i      (den_q),
      .sign_i     (sign_q),
      .quotient_o (final_s)
   );

   // Trial subtraction for one restoring step. The remainder is always below
   // the divisor magnitude, so the shifted value fits in N+1 bits and bit N of
   // the difference is a valid borrow/sign indicator.
   always_comb begin
      shift_s = {rem_q, num_q[MW-1]};
      diff_s  = shift_s - {1'b0, den_q};
      qbit_s  = ~diff_s[N];
   end

   // Next-state and output logic.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      num_d     = num_q;
      rem_d     = rem_q;
      den_d     = den_q;
      sign_d    = sign_q;
      dz_pend_d = dz_pend_q;
      quot_d    = quot_q;
      fin_d     = fin_q;
      busy_d    = busy_q;
      dbz_d     = dbz_q;
      case (state_q)
         IDLE, DONE: begin
            if (dz_pend_q) begin
               // Second cycle of a zero-divisor start: publish the saturated
               // result. A start request here is not taken so the flagged
               // result is always seen for at least one cycle.
               dz_pend_d = 1'b0;
               fin_d     = 1'b1;
               dbz_d     = 1'b1;
               quot_d    = sign_q ? QMIN_C : QMAX_C;
            end else if (div_if.enable) begin
               fin_d  = 1'b0;
               dbz_d  = 1'b0;
               sign_d = div_if.dividend[N-1] ^ div_if.divisor[N-1];
               num_d  = {mag_of(div_if.dividend), {FRAC{1'b0}}};
               den_d  = mag_of(div_if.divisor);
               rem_d  = {N{1'b0}};
               cnt_d  = {CW{1'b0}};
               if (div_if.divisor == {N{1'b0}}) begin
                  state_d   = DONE;
                  dz_pend_d = 1'b1;
                  busy_d    = 1'b0;
               end else begin
                  state_d = RUN;
                  busy_d  = 1'b1;
               end
            end else begin
               state_d = state_q;
            end
         end
         RUN: begin
            num_d = {num_q[MW-2:0], qbit_s};
            rem_d = qbit_s ? diff_s[N-1:0] : shift_s[N-1:0];
            if (cnt_q == LAST_C) begin
               cnt_d   = {CW{1'b0}};
               state_d = FIX;
            end else begin
               cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
            end
         end
         FIX: begin
            quot_d  = final_s;
            fin_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = DONE;
         end
         default: begin
            state_d   = IDLE;
            dz_pend_d = 1'b0;
            fin_d     = 1'b0;
            busy_d    = 1'b0;
            dbz_d     = 1'b0;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         cnt_q     <= {CW{1'b0}};
         num_q     <= {MW{1'b0}};
         rem_q     <= {N{1'b0}};
         den_q     <= {N{1'b0}};
         sign_q    <= 1'b0;
         dz_pend_q <= 1'b0;
         quot_q    <= {N{1'b0}};
         fin_q     <= 1'b0;
         busy_q    <= 1'b0;
         dbz_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         num_q     <= num_d;
         rem_q     <= rem_d;
         den_q     <= den_d;
         sign_q    <= sign_d;
         dz_pend_q <= dz_pend_d;
         quot_q    <= quot_d;
         fin_q     <= fin_d;
         busy_q    <= busy_d;
         dbz_q     <= dbz_d;
      end
   end

   assign div_if.quotient    = quot_q;
   assign div_if.finish      = fin_q;
   assign div_if.busy        = busy_q;
   assign div_if.div_by_zero = dbz_q;

endmodule : fixed_point_divider

// File: tb/tb_fixed_point_divider.sv
module tb_fixed_point_divider;
   import fc_fixed_pkg::*;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] q;
      logic        dz;
      int          lat;
   } vec_t;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;

   fixed_point_divider_if #(.N(16)) dif ();

   fixed_point_divider #(.N(16), .FRAC(10)) dut (
      .clk    (clk),
      .reset  (reset),
      .div_if (dif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   // Reference: exact rational arithmetic on integers, then round/truncate,
   // sign and clamp.
   task automatic model(input logic [15:0] a, input logic [15:0] b,
                        output logic [15:0] q, output logic dz);
      longint na, nb, num, an, ab, qm, r, qs;
      na = longint'($signed(a));
      nb = longint'($signed(b));
      if (nb == 0) begin
         dz = 1'b1;
         q  = (na >= 0) ? FC_QMAX : FC_QMIN;
      end else begin
         dz  = 1'b0;
         num = na * 1024;
         an  = (num < 0) ? -num : num;
         ab  = (nb < 0) ? -nb : nb;
         qm  = an / ab;
         r   = an % ab;
`ifdef FIXED_DIV_ROUND_EN
         if (2 * r >= ab) qm = qm + 1;
`endif
         qs = ((na < 0) != (nb < 0)) ? -qm : qm;
         if (qs > 32767)  qs = 32767;
         if (qs < -32768) qs = -32768;
         q = 16'(qs);
      end
   endtask

   task automatic start(input logic [15:0] a, input logic [15:0] b);
      @(negedge clk);
      dif.enable   = 1'b1;
      dif.dividend = a;
      dif.divisor  = b;
      @(posedge clk);
      #1;
      dif.enable = 1'b0;
   endtask

   // Counts edges after the accepting edge until finish; bounded.
   task automatic wait_finish(output int lat, output int bcnt);
      lat  = 0;
      bcnt = dif.busy ? 1 : 0;
      while (!dif.finish && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
         if (dif.busy) bcnt++;
      end
      if (!dif.finish) begin
         n_checks++;
         n_fail++;
         $display("FAIL timeout: finish not seen within %0d cycles", lat);
      end
   endtask

   task automatic run(input logic [15:0] a, input logic [15:0] b,
                      output logic [15:0] q, output logic dz, output int lat, output int bcnt);
      start(a, b);
      wait_finish(lat, bcnt);
      q  = dif.quotient;
      dz = dif.div_by_zero;
   endtask

   vec_t        vecs [12];
   logic [15:0] q, eq;
   logic        dz, edz;
   int          lat, bcnt;

   initial begin
      n_checks     = 0;
      n_fail       = 0;
      dif.enable   = 1'b0;
      dif.dividend = 16'h0000;
      dif.divisor  = 16'h0000;
      reset        = 1'b0;

      vecs[0]  = '{16'h0C00, 16'h0600, 16'h0800, 1'b0, 27};
`ifdef FIXED_DIV_ROUND_EN
      vecs[1]  = '{16'h0800, 16'h0C00, 16'h02AB, 1'b0, 27};
      vecs[2]  = '{16'hF800, 16'h0C00, 16'hFD55, 1'b0, 27};
`else
      vecs[1]  = '{16'h0800, 16'h0C00, 16'h02AA, 1'b0, 27};
      vecs[2]  = '{16'hF800, 16'h0C00, 16'hFD56, 1'b0, 27};
`endif
      vecs[3]  = '{16'h4000, 16'h0040, 16'h7FFF, 1'b0, 27};
      vecs[4]  = '{16'h4000, 16'hFFC0, 16'h8000, 1'b0, 27};
      vecs[5]  = '{16'hEC00, 16'h0000, 16'h8000, 1'b1, 1};
      vecs[6]  = '{16'h0000, 16'h0000, 16'h7FFF, 1'b1, 1};
      vecs[7]  = '{16'h8000, 16'hFFFF, 16'h7FFF, 1'b0, 27};
      vecs[8]  = '{16'h8000, 16'h0400, 16'h8000, 1'b0, 27};
      vecs[9]  = '{16'h7FFF, 16'h0400, 16'h7FFF, 1'b0, 27};
      vecs[10] = '{16'h0001, 16'h0C00, 16'h0000, 1'b0, 27};
      vecs[11] = '{16'h0000, 16'hFC00, 16'h0000, 1'b0, 27};

      #12;
      check("reset_quotient", 32'(dif.quotient), 32'h0);
      check("reset_finish", 32'(dif.finish), 32'h0);
      check("reset_busy", 32'(dif.busy), 32'h0);
      check("reset_dbz", 32'(dif.div_by_zero), 32'h0);
      @(negedge clk);
      reset = 1'b1;

      // Directed table.
      for (int i = 0; i < 12; i++) begin
         run(vecs[i].a, vecs[i].b, q, dz, lat, bcnt);
         check($sformatf("vec%0d_quotient", i), 32'(q), 32'(vecs[i].q));
         check($sformatf("vec%0d_dbz", i), 32'(dz), 32'(vecs[i].dz));
         check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
         check($sformatf("vec%0d_busy_cycles", i), 32'(bcnt),
               32'((vecs[i].lat == 27) ? 27 : 0));
      end

      // Result held in DONE.
      repeat (3) @(posedge clk);
      #1;
      check("hold_finish", 32'(dif.finish), 32'h1);
      check("hold_quotient", 32'(dif.quotient), 32'(vecs[11].q));

      // Start from DONE: finish falls on the accepting edge.
      start(16'h0C00, 16'h0600);
      check("restart_finish_low", 32'(dif.finish), 32'h0);
      check("restart_busy", 32'(dif.busy), 32'h1);
      wait_finish(lat, bcnt);
      check("restart_quotient", 32'(dif.quotient), 32'h0800);
      check("restart_latency", 32'(lat), 32'd27);

      // Enable pulsed during RUN with other operands is ignored.
      start(16'h0C00, 16'h0600);
      lat = 0;
      while (!dif.finish && lat < 40) begin
         if (lat == 5) begin
            @(negedge clk);
            dif.enable   = 1'b1;
            dif.dividend = 16'h0800;
            dif.divisor  = 16'h0C00;
            @(posedge clk);
            #1;
            dif.enable = 1'b0;
         end else begin
            @(posedge clk);
            #1;
         end
         lat++;
      end
      check("ignore_latency", 32'(lat), 32'd27);
      check("ignore_quotient", 32'(dif.quotient), 32'h0800);

      // Asynchronous reset at cycle 10 of RUN.
      start(16'h0800, 16'h0C00);
      repeat (10) @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      check("midreset_quotient", 32'(dif.quotient), 32'h0);
      check("midreset_finish", 32'(dif.finish), 32'h0);
      check("midreset_busy", 32'(dif.busy), 32'h0);
      check("midreset_dbz", 32'(dif.div_by_zero), 32'h0);
      @(negedge clk);
      reset = 1'b1;
      run(16'h0C00, 16'h0600, q, dz, lat, bcnt);
      check("postreset_quotient", 32'(q), 32'h0800);
      check("postreset_latency", 32'(lat), 32'd27);

      // Randomized operands against the arithmetic reference.
      for (int i = 0; i < 60; i++) begin
         logic [15:0] ra, rb;
         ra = 16'($urandom);
         case (i % 4)
            0:       rb = 16'($urandom);
            1:       rb = 16'($urandom_range(0, 255));
            2:       rb = 16'(-$signed(17'($urandom_range(1, 4096))));
            default: rb = (i % 16 == 3) ? 16'h0000 : 16'($urandom_range(0, 2047));
         endcase
         model(ra, rb, eq, edz);
         run(ra, rb, q, dz, lat, bcnt);
         check($sformatf("rand%0d_quotient(%h/%h)", i, ra, rb), 32'(q), 32'(eq));
         check($sformatf("rand%0d_dbz", i), 32'(dz), 32'(edz));
         check($sformatf("rand%0d_latency", i), 32'(lat), 32'(edz ? 1 : 27));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_fixed_point_divider

// File: doc/fixed_point_divider.md
# fixed_point_divider

Sequential signed fixed-point divider for the FC datapath. It is the inverse counterpart of the shift-add Booth multiplier and produces one quotient bit per clock using restoring division on magnitudes. The FC normalization and scaling stages use it to divide Q-format activations by Q-format scale factors. It has a start/finish handshake, a divide-by-zero flag, and saturates its output to the 16-bit Q format.

## Interface
- `N`, 16, operand and result width (signed two's complement).
- `FRAC`, 10, number of fractional bits; operands and result share the same Q(N-FRAC-1).FRAC format.
- `clk` input 1: the single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low reset (clears all state when 0).
- `enable` input 1: start request; sampled only in IDLE or DONE.
- `dividend` input N: signed Q-format numerator, latched on an accepted start.
- `divisor` input N: signed Q-format denominator, latched on an accepted start.
- `quotient` output N: signed Q-format result; valid while `finish`=1.
- `finish` output 1: result valid; held until the next accepted start.
- `busy` output 1: high in RUN and FIX.
- `div_by_zero` output 1: qualifies `quotient` when `finish`=1.

## Operation
- States are IDLE, RUN, FIX and DONE. Reset enters IDLE.
- Reset values: `quotient`=0, `finish`=0, `busy`=0, `div_by_zero`=0, iteration counter=0, state=IDLE.
- Start handling:
  - A start is accepted when `enable`=1 in IDLE or DONE.
  - On acceptance the block latches the operands, clears `finish` and `div_by_zero`, and stores the result sign as `dividend[N-1] ^ divisor[N-1]`.
  - The numerator magnitude is `|dividend| << FRAC`, width N+FRAC, which covers -2^(N-1) without overflow.
  - The denominator magnitude is `|divisor|`, width N.
- Divide by zero: if `divisor`==0 at acceptance, the next state is DONE directly.
  - `quotient` = 0x7FFF when `dividend` >= 0, or 0x8000 when `dividend` < 0.
  - `div_by_zero`=1 and `finish`=1.
- RUN: N+FRAC iterations (26 at defaults).
  - Each iteration shifts the partial remainder left by one and brings in the next numerator bit.
  - It trial-subtracts the denominator. If the result is non-negative, the remainder is updated and quotient bit = 1; otherwise quotient bit = 0.
  - The counter increments each iteration. After the last iteration the next state is FIX.
- FIX (one cycle):
  - Applies the optional rounding.
  - Negates the magnitude if the result sign is 1.
  - Saturates: a positive magnitude above 2^(N-1)-1 gives 0x7FFF; a negative magnitude above 2^(N-1) gives 0x8000.
  - Registers `quotient`, sets `finish`=1 and moves to DONE.
- Without rounding, results are truncated toward zero.
- `enable` in RUN or FIX is ignored; the operation in flight is not disturbed.
- DONE: outputs are held. `enable` in DONE is an accepted start, and `finish` falls on the next edge.
- Reset asserted mid-operation aborts the operation immediately (asynchronously) and returns every output to its reset value.

## Timing
- Normal latency: a start accepted at edge E0 raises `finish` after edge E0+N+FRAC+1, which is 27 cycles at defaults.
- `busy` is high from after E0 until the edge that raises `finish`.
- Divide-by-zero latency: `finish` rises after edge E0+1.
- Back-to-back operation: `enable` held high in DONE restarts on the same edge; throughput is one result per 28 cycles.
- No combinational path exists from any input to any output.

## Configuration
- Macro: `FIXED_DIV_ROUND_EN`.
- Defined: FIX computes `2*remainder >= divisor_mag`. If true it adds 1 to the magnitude before sign and saturation, giving round half away from zero.
- Undefined: truncation toward zero; the remainder is unused in FIX.
- Latency is identical in both builds.

## Structure
- The shared package `fc_fixed_pkg` holds:
  - the Q-format constants `FC_N` and `FC_FRAC`;
  - the saturation limits `FC_QMAX` = 0x7FFF and `FC_QMIN` = 0x8000;
  - the state enum typedef `div_state_t` (IDLE, RUN, FIX, DONE).
- One sub-module, `fixed_div_finalize`, is combinational. It takes the magnitude, remainder, divisor magnitude and sign, and produces the rounded, negated and saturated N-bit quotient. It is instantiated once, with its output registered in FIX.

## Test plan
- 3.0 / 1.5: `dividend`=0x0C00, `divisor`=0x0600 -> `quotient`=0x0800. `finish` rises 27 cycles after start; `busy` is high for 27 cycles.
- 2/3: `dividend`=0x0800, `divisor`=0x0C00 -> 0x02AA (truncate) or 0x02AB (`FIXED_DIV_ROUND_EN`). Repeat with `dividend`=0xF800 -> 0xFD56 or 0xFD55 respectively.
- Saturation: 16.0 / 0.0625 (0x4000 / 0x0040) -> 0x7FFF. Sign flipped (`divisor`=0xFFC0) -> 0x8000. `div_by_zero`=0 in both cases.
- Divide by zero: `dividend`=0xEC00, `divisor`=0 -> `quotient`=0x8000, `div_by_zero`=1, `finish` one cycle after start.
- `enable` pulsed during RUN with different operands -> ignored; the original result is delivered at cycle 27.
- `reset` driven low at cycle 10 of RUN -> all outputs 0 immediately. After `reset` is released, a new start with 0x0C00 / 0x0600 returns 0x0800.
